instruction_register: RTL and testbench



---
 rtl/instruction_register_if.sv | 29 ++
 rtl/instruction_register.sv | 51 +++++
 tb/tb_instruction_register.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instruction_register_if.sv
// Instruction-register bus interface: W-bus capture/drive lines and the
// opcode feed to the control unit. The master side is the controller/bus;
// the slave side is the instruction register itself.
interface instruction_register_if #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned OP_W   = 4
);
   logic [WORD_W-1:0]      BusIn;
   logic                   IRIn;
   logic                   IROut;
   logic [WORD_W-OP_W-1:0] BusOut;
   logic [OP_W-1:0]        CUIn;

   modport master (
      output BusIn,
      output IRIn,
      output IROut,
      input  BusOut,
      input  CUIn
   );

   modport slave (
      input  BusIn,
      input  IRIn,
      input  IROut,
      output BusOut,
      output CUIn
   );
endinterface

// File: rtl/instruction_register.sv
// Instruction register of the 8-bit SAP computer.
// Captures an instruction word from the W-bus, feeds the opcode nibble to the
// control unit continuously and drives the operand nibble back onto the bus
// when enabled.
// Optional build macro IR_TRISTATE_EN: when defined, BusOut floats (z) while
// IROut=0; otherwise it is driven to zero so several sources can be OR-ed.
module instruction_register #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned OP_W   = 4
) (
   instruction_register_if.slave irBus,
   input  logic                  clk,
   input  logic                  rst
);
   localparam int unsigned OPND_W = WORD_W - OP_W;

   logic [WORD_W-1:0] irQ;
   logic [WORD_W-1:0] irD;

   // Next state: load from the bus when enabled, otherwise hold.
   always_comb begin
      irD = irQ;
      if (irBus.IRIn) begin
         irD = irBus.BusIn;
      end
   end

   // Instruction word storage; reset clears it without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irQ <= '0;
      end else begin
         irQ <= irD;
      end
   end

   // Opcode is always visible to the control unit.
   assign irBus.CUIn = irQ[WORD_W-1 -: OP_W];

   // Operand drive: only from the register, so BusIn never reaches BusOut.
   always_comb begin
`ifdef IR_TRISTATE_EN
      irBus.BusOut = 'z;
`else
      irBus.BusOut = '0;
`endif
      if (irBus.IROut) begin
         irBus.BusOut = irQ[OPND_W-1:0];
      end
   end
endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard bench for instruction_register: stimulus pushes expected
// opcode/operand values and signals a sample; a monitor pops and compares.
module tb_instruction_register;
   logic clk;
   logic rst;

   instruction_register_if #(.WORD_W(8), .OP_W(4)) irBus ();

   instruction_register #(.WORD_W(8), .OP_W(4)) dut (
      .irBus (irBus.slave),
      .clk   (clk),
      .rst   (rst)
   );

`ifdef IR_TRISTATE_EN
   localparam logic [3:0] BoOff = 4'bzzzz;
`else
   localparam logic [3:0] BoOff = 4'h0;
`endif

   typedef struct {
      string      name;
      logic [3:0] cu;
      logic [3:0] bo;
   } exp_t;

   exp_t expQ[$];
   event sampleEv;
   int   nTests = 0;
   int   nFail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Let inputs settle, queue the expectation, then hand off to the monitor.
   task automatic expectOut(input string nm, input logic [3:0] cu, input logic [3:0] bo);
      exp_t e;
      #1;
      e.name = nm;
      e.cu   = cu;
      e.bo   = bo;
      expQ.push_back(e);
      -> sampleEv;
      #1;
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(sampleEv);
         nTests++;
         if (expQ.size() == 0) begin
            nFail++;
            $display("FAIL noExpect: sample requested with empty scoreboard");
         end else begin
            e = expQ.pop_front();
            if (irBus.CUIn !== e.cu || irBus.BusOut !== e.bo) begin
               nFail++;
               $display("FAIL %s: CUIn=%h BusOut=%h, required CUIn=%h BusOut=%h",
                        e.name, irBus.CUIn, irBus.BusOut, e.cu, e.bo);
            end
         end
      end
   end

   // Stimulus
   initial begin
      int waitCnt;
      rst         = 1'b0;
      irBus.BusIn = 8'h00;
      irBus.IRIn  = 1'b0;
      irBus.IROut = 1'b0;

      // Async reset at 7ns, no clock edge before the check.
      #7 rst = 1'b1;
      expectOut("rstAsync", 4'h0, BoOff);
      #3;
      rst         = 1'b0;
      irBus.BusIn = 8'h35;
      irBus.IRIn  = 1'b1;
      @(posedge clk);
      expectOut("load", 4'h3, BoOff);
      irBus.IRIn = 1'b0;
      #4 irBus.IROut = 1'b1;
      expectOut("outEn", 4'h3, 4'h5);
      irBus.IROut = 1'b0;
      expectOut("outDis", 4'h3, BoOff);

      // Hold: bus keeps changing, load disabled.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         irBus.BusIn = (i % 2 == 0) ? 8'hA7 : 8'h5A;
         @(posedge clk);
         expectOut("hold", 4'h3, BoOff);
      end
      @(negedge clk);
      irBus.IROut = 1'b1;
      expectOut("holdOut", 4'h3, 4'h5);

      // Reset arriving mid-load.
      @(negedge clk);
      irBus.BusIn = 8'hF2;
      irBus.IRIn  = 1'b1;
      @(posedge clk);
      expectOut("loadF2", 4'hF, 4'h2);
      rst = 1'b1;
      expectOut("rstMid", 4'h0, 4'h0);
      @(posedge clk);
      expectOut("rstPri", 4'h0, 4'h0);
      @(negedge clk);
      rst         = 1'b0;
      irBus.BusIn = 8'h9C;
      expectOut("rstLost", 4'h0, 4'h0);
      @(posedge clk);
      expectOut("reload", 4'h9, 4'hC);

      // Load and output enable together: old operand until the edge.
      @(negedge clk);
      irBus.BusIn = 8'h4B;
      expectOut("simulOld", 4'h9, 4'hC);
      @(posedge clk);
      expectOut("simulNew", 4'h4, 4'hB);
      irBus.IRIn  = 1'b0;
      irBus.IROut = 1'b0;
      expectOut("finalOff", 4'h4, BoOff);

      // Every expectation must have been consumed by the monitor.
      waitCnt = 0;
      while (expQ.size() != 0 && waitCnt < 10) begin
         @(posedge clk);
         waitCnt++;
      end
      nTests++;
      if (expQ.size() != 0) begin
         nFail++;
         $display("FAIL drain: %0d expectations left, required 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end
endmodule
